// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8E1/8O1 (optionally two stop bits) framing with a
// per-bit baud counter; serial line and ready flag come straight from flops.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD  = (PARITY == 1);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          stop_idx;
  logic          bit_done;

  assign bit_done = (baud_cnt == LAST_CNT);

  // Parity is captured at accept time because the shift register is consumed
  // as the data bits go out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      tx_o       <= 1'b1;
      tx_ready_o <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      stop_idx   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_o       <= 1'b1;
          tx_ready_o <= 1'b1;
          if (tx_ready_o && tx_start_i) begin
            shift_reg  <= tx_data_i;
            par_bit    <= PAR_ODD ? ~^tx_data_i : ^tx_data_i;
            state      <= ST_START;
            tx_o       <= 1'b0;
            tx_ready_o <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_cnt  <= '0;
            state     <= ST_DATA;
            tx_o      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PAR_EN) begin
                state <= ST_PARITY;
                tx_o  <= par_bit;
              end else begin
                state <= ST_STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_o      <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= ST_STOP;
            tx_o     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (TWO_STOP && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state      <= ST_IDLE;
              tx_ready_o <= 1'b1;
            end
            tx_o <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          tx_o       <= 1'b1;
          tx_ready_o <= 1'b1;
          baud_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances cover no/even/odd parity and
// two stop bits; expected line bits are queued at stimulus time and checked per cycle.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rstn;
  logic [3:0] start;
  logic [3:0] tx;
  logic [3:0] rdy;
  logic [7:0] data [4];

  int vectors;
  int errors;
  bit exp_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rstn(rstn), .tx_start_i(start[0]), .tx_data_i(data[0]),
    .tx_ready_o(rdy[0]), .tx_o(tx[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rstn(rstn), .tx_start_i(start[1]), .tx_data_i(data[1]),
    .tx_ready_o(rdy[1]), .tx_o(tx[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rstn(rstn), .tx_start_i(start[2]), .tx_data_i(data[2]),
    .tx_ready_o(rdy[2]), .tx_o(tx[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rstn(rstn), .tx_start_i(start[3]), .tx_data_i(data[3]),
    .tx_ready_o(rdy[3]), .tx_o(tx[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_mode(input int sel);
    return (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
  endfunction

  function automatic int stop_cnt(input int sel);
    return (sel == 3) ? 2 : 1;
  endfunction

  function automatic int frame_bits(input int sel);
    return 9 + ((par_mode(sel) != 0) ? 1 : 0) + stop_cnt(sel);
  endfunction

  task automatic check_output(input string tag, input logic actual, input logic expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  // Expected serial line contents for one frame, derived only from the byte and the instance setup.
  task automatic push_frame(input int sel, input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (par_mode(sel) == 2) exp_q.push_back(^d);
    if (par_mode(sel) == 1) exp_q.push_back(~^d);
    for (int i = 0; i < stop_cnt(sel); i++) exp_q.push_back(1'b1);
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic apply_stimulus(input int sel, input logic [7:0] d, input bit hold);
    data[sel]  = d;
    start[sel] = 1'b1;
    push_frame(sel, d);
    @(posedge clk);
    #1;
    if (!hold) start[sel] = 1'b0;
  endtask

  task automatic check_frame(input int sel, input int poke_cycle, input int abort_cycle);
    int k;
    bit exp_bit;
    k = 0;
    for (int b = 0; b < frame_bits(sel); b++) begin
      exp_bit = exp_q.pop_front();
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check_output($sformatf("d%0d tx k=%0d", sel, k), tx[sel], exp_bit);
        check_output($sformatf("d%0d busy k=%0d", sel, k), rdy[sel], 1'b0);
        if (k == poke_cycle) begin
          data[sel]  = 8'h00;
          start[sel] = 1'b1;
        end
        if (k == poke_cycle + 2) start[sel] = 1'b0;
        if (k == abort_cycle) begin
          rstn = 1'b0;
          #1;
          check_output($sformatf("d%0d abort tx", sel), tx[sel], 1'b1);
          check_output($sformatf("d%0d abort rdy", sel), rdy[sel], 1'b1);
          exp_q.delete();
          return;
        end
        k++;
      end
    end
    @(negedge clk);
    check_output($sformatf("d%0d end tx", sel), tx[sel], 1'b1);
    check_output($sformatf("d%0d end rdy", sel), rdy[sel], 1'b1);
  endtask

  task automatic check_idle(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_output($sformatf("d%0d idle tx", sel), tx[sel], 1'b1);
      check_output($sformatf("d%0d idle rdy", sel), rdy[sel], 1'b1);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rstn    = 1'b0;
    start   = '0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("d%0d reset tx", i), tx[i], 1'b1);
      check_output($sformatf("d%0d reset rdy", i), rdy[i], 1'b1);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Basic frames on each configuration
    apply_stimulus(0, 8'h41, 1'b0);
    check_frame(0, -1, -1);
    @(negedge clk);
    apply_stimulus(1, 8'h41, 1'b0);
    check_frame(1, -1, -1);
    @(negedge clk);
    apply_stimulus(2, 8'h41, 1'b0);
    check_frame(2, -1, -1);
    @(negedge clk);
    apply_stimulus(3, 8'hFF, 1'b0);
    check_frame(3, -1, -1);

    // Held request: back-to-back frames with one idle cycle between them
    @(negedge clk);
    apply_stimulus(0, 8'h55, 1'b1);
    check_frame(0, -1, -1);
    apply_stimulus(0, 8'hAA, 1'b0);
    check_frame(0, -1, -1);
    check_idle(0, 3);

    // Mid-frame data change and start pulse must not disturb the frame
    @(negedge clk);
    apply_stimulus(0, 8'hC3, 1'b0);
    check_frame(0, 10, -1);
    check_idle(0, 6);

    // Reset during data bit 3, then accept on the first edge after release
    @(negedge clk);
    apply_stimulus(0, 8'h41, 1'b0);
    check_frame(0, -1, 17);
    @(negedge clk);
    check_output("d0 in reset tx", tx[0], 1'b1);
    check_output("d0 in reset rdy", rdy[0], 1'b1);
    rstn = 1'b1;
    apply_stimulus(0, 8'h41, 1'b0);
    check_frame(0, -1, -1);

    // A few random bytes on the parity configurations
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply_stimulus(1 + (i % 2), 8'($urandom_range(0, 255)), 1'b0);
      check_frame(1 + (i % 2), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal values >= 2.
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits: 1 or 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tx_start_i, input, 1, level request to send tx_data_i.
REQ-007 SHALL have port tx_data_i, input, 8, byte to transmit.
REQ-008 SHALL have port tx_ready_o, output, 1, high when idle and able to accept a byte.
REQ-009 SHALL have port tx_o, output, 1, serial line, idle high, LSB first.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL accept a byte only on a rising edge where state = IDLE, tx_ready_o = 1 and tx_start_i = 1; tx_data_i is latched into an internal shift register at that edge.
REQ-012 SHALL drive tx_ready_o low and tx_o low (start bit) in the cycle immediately after the accept edge, i.e. one cycle of latency.
REQ-013 SHALL hold each bit on tx_o for exactly CLKS_PER_BIT cycles, using a baud counter of width clog2(CLKS_PER_BIT) that reloads at every bit boundary.
REQ-014 SHALL transmit in order: 1 start bit (0), 8 data bits LSB first, parity bit if PARITY != 0, then STOP_BITS stop bits (1).
REQ-015 SHALL compute parity from the latched byte: even mode gives XOR of the 8 bits; odd mode gives its inverse.
REQ-016 SHALL count data bits with a 3-bit index and leave DATA after index 7 completes.
REQ-017 SHALL keep tx_ready_o low for exactly F = (1 + 8 + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles per frame.
REQ-018 SHALL return to IDLE with tx_ready_o = 1 and tx_o = 1 in the cycle after the last stop-bit cycle.
REQ-019 SHALL spend at least one cycle in IDLE with tx_ready_o = 1 between frames, even if tx_start_i is held high continuously; a held request then starts the next frame at the end of that cycle.
REQ-020 SHALL ignore tx_start_i and changes on tx_data_i while tx_ready_o = 0; the frame in flight is unaffected.
REQ-021 SHALL drive tx_o and tx_ready_o directly from flops, with no combinational path from inputs.
REQ-022 SHALL treat unsupported values of PARITY (other than 0, 1, 2) as none, and any STOP_BITS other than 2 as 1.

Reset
REQ-023 SHALL, while rstn = 0, force state IDLE, tx_o = 1, tx_ready_o = 1, and zero the baud counter, bit index and shift register.
REQ-024 SHALL, when reset is asserted mid-frame, abort the frame immediately (asynchronously) with tx_o = 1; no partial frame resumes after release.
REQ-025 SHALL be able to accept a byte on the first rising edge after rstn deasserts.

Verification
REQ-026 CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; pulse tx_start_i with 8'h41 -> tx_o shows 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles; tx_ready_o low for 40 cycles, then high.
REQ-027 PARITY=2, then PARITY=1, data 8'h41 -> parity bit 0 (even) and 1 (odd) after data bit 7; frame is 44 cycles.
REQ-028 STOP_BITS=2, data 8'hFF -> start bit followed by 10 high bits, 44 cycles; tx_ready_o rises exactly at cycle 44.
REQ-029 Hold tx_start_i high with data 8'h55, then 8'hAA -> two back-to-back frames separated by exactly one idle cycle with tx_ready_o=1; second frame carries the data present at that cycle.
REQ-030 Change tx_data_i to 8'h00 and pulse tx_start_i in mid-frame of 8'hC3 -> transmitted bits remain those of 8'hC3; no extra frame is sent.
REQ-031 Assert rstn=0 during data bit 3 -> tx_o=1 and tx_ready_o=1 immediately; after release, a new 8'h41 frame is transmitted correctly.
